// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer and the datapath.
// Latency: none, wiring only.
// Backpressure: mem_done is the only stall input; the sequencer holds its strobes until it is seen.
interface control_sequencer_if #(
  parameter int OPW = 5
);
  logic            start;
  logic            stop;
  logic [31:0]     ir;
  logic            mem_done;
  logic [15:0]     reg_in;
  logic [15:0]     reg_out;
  logic            PCout;
  logic            PCin;
  logic            IncPC;
  logic            MARin;
  logic            MDRin;
  logic            MDRout;
  logic            IRin;
  logic            Yin;
  logic            Zin;
  logic            Zlowout;
  logic            Zhighout;
  logic            HIin;
  logic            LOin;
  logic            Cout;
  logic            read;
  logic            write;
  logic [OPW-1:0]  alu_op;
  logic            run;
  logic            illegal;
  logic            bus_error;

  // Sequencer side: consumes requests and memory status, drives every strobe.
  modport master (
    input  start, stop, ir, mem_done,
    output reg_in, reg_out, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, read, write,
           alu_op, run, illegal, bus_error
  );

  // Datapath / memory side: mirror image of the sequencer view.
  modport slave (
    output start, stop, ir, mem_done,
    input  reg_in, reg_out, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, read, write,
           alu_op, run, illegal, bus_error
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch T0-T3, decode, execute E0-E4 for the single-bus datapath.
// Latency: one state per clock; strobes are registered from the next state so they span the whole state.
// Backpressure: memory states hold until mem_done; MEM_TIMEOUT misses raise sticky bus_error and halt.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int OPW         = 5
) (
  input  logic                clock,
  input  logic                clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_HALTED, S_T0, S_T1, S_T2, S_T3, S_DEC,
    S_E0, S_E1, S_E2, S_E3, S_E4
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_ADDI, C_LD, C_ST, C_MULDIV, C_NOP, C_HALT
  } cls_t;

  typedef struct packed {
    logic [15:0]    reg_in;
    logic [15:0]    reg_out;
    logic           pc_out;
    logic           pc_in;
    logic           inc_pc;
    logic           mar_in;
    logic           mdr_in;
    logic           mdr_out;
    logic           ir_in;
    logic           y_in;
    logic           z_in;
    logic           zlow_out;
    logic           zhigh_out;
    logic           hi_in;
    logic           lo_in;
    logic           c_out;
    logic           read;
    logic           write;
    logic [OPW-1:0] alu_op;
    logic           run;
  } ctl_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [4:0]  op_q, op_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [3:0]  rc_q, rc_d;
  logic [7:0]  wait_q, wait_d;
  logic        bus_error_q, bus_error_d;
  logic        stop_pend_q, stop_pend_d;
  ctl_t        ctl_q, ctl_d;

  state_t      finish_state;
  logic        in_wait;

  logic [4:0]  ir_op;
  logic [3:0]  ir_ra, ir_rb, ir_rc;
  logic [14:0] unused_ir_low;

  assign ir_op         = bus.ir[31:27];
  assign ir_ra         = bus.ir[26:23];
  assign ir_rb         = bus.ir[22:19];
  assign ir_rc         = bus.ir[18:15];
  assign unused_ir_low = bus.ir[14:0];

  function automatic cls_t decode_op(input logic [4:0] op);
    cls_t c;
    c = C_NOP;
    if (op <= 5'h0B) begin
      c = C_ALU;
    end else begin
      case (op)
        5'h0C:        c = C_ADDI;
        5'h0D:        c = C_LD;
        5'h0E:        c = C_ST;
        5'h0F, 5'h10: c = C_MULDIV;
        5'h1F:        c = C_HALT;
        default:      c = C_NOP;
      endcase
    end
    return c;
  endfunction

  function automatic logic op_defined(input logic [4:0] op);
    return (op <= 5'h10) || (op == 5'h1E) || (op == 5'h1F);
  endfunction

  // Next state, instruction latch, stop bookkeeping and memory wait guard.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    op_d         = op_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    rc_d         = rc_q;
    wait_d       = '0;
    bus_error_d  = bus_error_q;
    stop_pend_d  = stop_pend_q | bus.stop;
    in_wait      = 1'b0;
    // stop seen anywhere since T0 (including this cycle) turns the end of the instruction into a halt
    finish_state = (stop_pend_q || bus.stop) ? S_HALTED : S_T0;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (bus.start) state_d = S_T0;
      end
      S_HALTED: begin
        stop_pend_d = 1'b0;
        // a timeout can only be cleared by reset
        if (bus.start && !bus_error_q) state_d = S_T0;
      end
      S_T0: begin
        stop_pend_d = bus.stop;
        state_d     = S_T1;
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        in_wait = 1'b1;
        state_d = S_T3;
      end
      S_T3: state_d = S_DEC;
      S_DEC: begin
        cls_d = decode_op(ir_op);
        op_d  = ir_op;
        ra_d  = ir_ra;
        rb_d  = ir_rb;
        rc_d  = ir_rc;
        case (cls_d)
          C_NOP:   state_d = finish_state;
          C_HALT:  state_d = S_HALTED;
          default: state_d = S_E0;
        endcase
      end
      S_E0: state_d = S_E1;
      S_E1: state_d = S_E2;
      S_E2: state_d = (cls_q == C_ALU || cls_q == C_ADDI) ? finish_state : S_E3;
      S_E3: begin
        in_wait = (cls_q == C_LD);
        state_d = (cls_q == C_MULDIV) ? finish_state : S_E4;
      end
      S_E4: begin
        in_wait = (cls_q == C_ST);
        state_d = finish_state;
      end
      default: state_d = S_IDLE;
    endcase

    // a memory state without mem_done stays put unless it has run out of patience
    if (in_wait && !bus.mem_done) begin
      if (wait_q + 8'd1 >= TIMEOUT) begin
        bus_error_d = 1'b1;
        state_d     = S_HALTED;
      end else begin
        wait_d  = wait_q + 8'd1;
        state_d = state_q;
      end
    end
  end

  // Strobe decode for the state about to be entered, using the fields it will see.
  always_comb begin
    ctl_d     = '0;
    ctl_d.run = (state_d != S_IDLE) && (state_d != S_HALTED);
    case (state_d)
      S_T0: begin
        ctl_d.pc_out = 1'b1;
        ctl_d.mar_in = 1'b1;
        ctl_d.inc_pc = 1'b1;
        ctl_d.z_in   = 1'b1;
      end
      S_T1: begin
        ctl_d.zlow_out = 1'b1;
        ctl_d.pc_in    = 1'b1;
      end
      S_T2: begin
        ctl_d.read   = 1'b1;
        ctl_d.mdr_in = 1'b1;
      end
      S_T3: begin
        ctl_d.mdr_out = 1'b1;
        ctl_d.ir_in   = 1'b1;
      end
      S_E0: begin
        ctl_d.y_in    = 1'b1;
        ctl_d.reg_out = (cls_d == C_MULDIV) ? (16'h0001 << ra_d) : (16'h0001 << rb_d);
      end
      S_E1: begin
        ctl_d.z_in = 1'b1;
        case (cls_d)
          C_ALU, C_MULDIV: begin
            ctl_d.reg_out = (cls_d == C_ALU) ? (16'h0001 << rc_d) : (16'h0001 << rb_d);
            ctl_d.alu_op  = OPW'(op_d);
          end
          default: begin
            // immediate/address add: constant onto the bus, plain ADD
            ctl_d.c_out  = 1'b1;
            ctl_d.alu_op = '0;
          end
        endcase
      end
      S_E2: begin
        ctl_d.zlow_out = 1'b1;
        case (cls_d)
          C_LD, C_ST: ctl_d.mar_in = 1'b1;
          C_MULDIV:   ctl_d.lo_in  = 1'b1;
          default:    ctl_d.reg_in = 16'h0001 << ra_d;
        endcase
      end
      S_E3: begin
        case (cls_d)
          C_LD: begin
            ctl_d.read   = 1'b1;
            ctl_d.mdr_in = 1'b1;
          end
          C_ST: begin
            // MDR loads from the bus (read=0 selects the bus side of the MDR mux)
            ctl_d.reg_out = 16'h0001 << ra_d;
            ctl_d.mdr_in  = 1'b1;
          end
          default: begin
            ctl_d.zhigh_out = 1'b1;
            ctl_d.hi_in     = 1'b1;
          end
        endcase
      end
      S_E4: begin
        if (cls_d == C_LD) begin
          ctl_d.mdr_out = 1'b1;
          ctl_d.reg_in  = 16'h0001 << ra_d;
        end else begin
          ctl_d.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, latched instruction fields and registered strobes.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= S_IDLE;
      cls_q       <= C_NOP;
      op_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      wait_q      <= '0;
      bus_error_q <= 1'b0;
      stop_pend_q <= 1'b0;
      ctl_q       <= '0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
      stop_pend_q <= stop_pend_d;
      ctl_q       <= ctl_d;
    end
  end

  assign bus.reg_in    = ctl_q.reg_in;
  assign bus.reg_out   = ctl_q.reg_out;
  assign bus.PCout     = ctl_q.pc_out;
  assign bus.PCin      = ctl_q.pc_in;
  assign bus.IncPC     = ctl_q.inc_pc;
  assign bus.MARin     = ctl_q.mar_in;
  assign bus.MDRin     = ctl_q.mdr_in;
  assign bus.MDRout    = ctl_q.mdr_out;
  assign bus.IRin      = ctl_q.ir_in;
  assign bus.Yin       = ctl_q.y_in;
  assign bus.Zin       = ctl_q.z_in;
  assign bus.Zlowout   = ctl_q.zlow_out;
  assign bus.Zhighout  = ctl_q.zhigh_out;
  assign bus.HIin      = ctl_q.hi_in;
  assign bus.LOin      = ctl_q.lo_in;
  assign bus.Cout      = ctl_q.c_out;
  assign bus.read      = ctl_q.read;
  assign bus.write     = ctl_q.write;
  assign bus.alu_op    = ctl_q.alu_op;
  assign bus.run       = ctl_q.run;
  assign bus.bus_error = bus_error_q;
  // IR only becomes valid in DEC, so the undefined-opcode pulse is decoded directly from it there
  assign bus.illegal   = (state_q == S_DEC) && !op_defined(ir_op);

endmodule
